mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 4096, RAM depth in bytes, mapped at 0x0000.
REQ-002 SHALL have parameter ROM_WORDS, default 4096, ROM depth in bytes, mapped at top of 64K space (0xF000 for default).
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, wait states inserted per access (0..15).
REQ-004 ph2  input  1  sole clock, all state updates on rising edge; one clock; reset is asynchronous and active-low.
REQ-005 reset_b  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  CPU access request.
REQ-007 req_rw  input  1  1 = read, 0 = write (6502 convention).
REQ-008 req_addr  input  16  byte address.
REQ-009 req_wdata  input  8  write data.
REQ-010 req_ready  output  1  responder can accept a request this cycle.
REQ-011 rsp_valid  output  1  one-cycle response strobe.
REQ-012 rsp_rdata  output  8  read data, valid with rsp_valid.
REQ-013 rsp_err  output  1  access error, valid with rsp_valid.
REQ-014 ld_en / ld_addr[11:0] / ld_data[7:0]  inputs  ROM load port, one byte per cycle.

Function
REQ-015 SHALL accept a request on an edge where req_valid and req_ready are both 1; req_addr/req_rw/req_wdata captured at acceptance.
REQ-016 SHALL implement states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 IDLE -> WAIT on acceptance if WAIT_CYCLES > 0, else IDLE -> RESP.
REQ-018 WAIT: down-counter loaded with WAIT_CYCLES-1 on acceptance; WAIT -> RESP when counter is 0.
REQ-019 RESP: rsp_valid = 1 for exactly one cycle, then -> IDLE; latency acceptance-to-rsp_valid = WAIT_CYCLES+1 cycles; back-to-back throughput one access per WAIT_CYCLES+2 cycles.
REQ-020 Decode: addr < RAM_WORDS -> RAM; addr >= 0x10000-ROM_WORDS -> ROM; else unmapped.
REQ-021 RAM read returns stored byte; RAM write commits on the edge leaving RESP, rsp_rdata = 0x00 for writes.
REQ-022 ROM read returns stored byte; ROM write discarded, contents unchanged.
REQ-023 ld_en writes ROM[ld_addr] on the edge, in any state; a same-edge ROM read of that address returns the old byte.
REQ-024 rsp_rdata and rsp_err SHALL hold 0 whenever rsp_valid = 0.
REQ-025 req_valid while req_ready = 0 SHALL be ignored (no queueing).

Reset
REQ-026 reset_b low SHALL force state IDLE, counter 0, req_ready 1 after release, rsp_valid 0, rsp_rdata 0x00, rsp_err 0.
REQ-027 Reset during WAIT/RESP SHALL abort the access: no response, no RAM write commit.
REQ-028 RAM and ROM contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro MEM_RESPONDER_ERR_EN: when defined, unmapped accesses and ROM writes return rsp_err = 1, rsp_rdata 0x00.
REQ-030 Without MEM_RESPONDER_ERR_EN: rsp_err tied 0; unmapped reads return 0xFF; unmapped and ROM writes silently dropped.

Structure
REQ-031 Shared package mem_pkg SHALL hold the state enum (IDLE/WAIT/RESP), address-region enum (RAM/ROM/UNMAPPED), and RAM/ROM base constants.
REQ-032 One sub-module mem_array (single-port byte array, sync write, parameter depth) SHALL be instantiated twice (RAM, ROM); hierarchical array names RAM and ROM SHALL stay accessible for bench preload.

Verification
REQ-033 Load ROM[0xFFD]=0xF0 via ld port, read 0xFFFD, WAIT_CYCLES=1 -> rsp_valid exactly 2 cycles after accept, rsp_rdata 0xF0.
REQ-034 Write 0x75 to 0x0004, then read 0x0004 -> rsp_rdata 0x75 (117); write 0x00 to 0x0123, read back -> 0x00.
REQ-035 Write 0xAA to 0xF010 -> ROM unchanged on read-back; rsp_err 1 with MEM_RESPONDER_ERR_EN, 0 without.
REQ-036 Read 0x8000 (unmapped) -> rsp_rdata 0xFF, rsp_err 0 without macro; 0x00, rsp_err 1 with macro.
REQ-037 Assert reset_b low during WAIT of a write 0x55 to 0x0010 (prior 0x22) -> no rsp_valid, read-back after reset 0x22.
REQ-038 WAIT_CYCLES=0, continuous req_valid -> one rsp_valid every 2 cycles, req_ready low in RESP.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and address-map constants for the memory responder.
// Holds the FSM state enum, region enum and the address decoder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_ROM,
        RGN_UNMAPPED
    } region_t;

    localparam int          ADDR_SPACE = 65536;
    localparam logic [15:0] RAM_BASE   = 16'h0000;

    // ROM sits flush against the top of the 64K space.
    function automatic logic [15:0] rom_base(input int rom_words);
        return 16'(ADDR_SPACE - rom_words);
    endfunction

    function automatic region_t decode(
        input logic [15:0] a,
        input int          ram_words,
        input int          rom_words
    );
        int ai;
        ai = int'(a);
        if (ai - int'(RAM_BASE) < ram_words)
            return RGN_RAM;
        if (ai >= int'(rom_base(rom_words)))
            return RGN_ROM;
        return RGN_UNMAPPED;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Byte array with one synchronous write port and an asynchronous read.
// Contents are never reset so preloaded data survives reset.
module mem_array #(
    parameter  int DEPTH = 4096,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Commit a byte on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// RAM/ROM responder for a 6502-style bus with programmable wait states.
// Define MEM_RESPONDER_ERR_EN to flag unmapped accesses and ROM writes.
module mem_responder
    import mem_pkg::*;
#(
    parameter int RAM_WORDS   = 4096,
    parameter int ROM_WORDS   = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        ph2,
    input  logic        reset_b,
    input  logic        req_valid,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    input  logic        ld_en,
    input  logic [11:0] ld_addr,
    input  logic [7:0]  ld_data
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int ROM_AW = $clog2(ROM_WORDS);

    localparam logic [3:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef MEM_RESPONDER_ERR_EN
    localparam logic       ERR_EN    = 1'b1;
    localparam logic [7:0] UNM_RDATA = 8'h00;
`else
    localparam logic       ERR_EN    = 1'b0;
    localparam logic [7:0] UNM_RDATA = 8'hFF;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        accept;

    logic        rw_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    region_t     region_q;

    logic        ram_we;
    logic [7:0]  ram_rd;
    logic [7:0]  rom_rd;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    // State and wait counter registers.
    always_ff @(posedge ph2 or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0)
                    state_nxt = RESP;
                else
                    cnt_nxt = cnt - 4'd1;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Capture the request and its decoded region at acceptance.
    always_ff @(posedge ph2 or negedge reset_b) begin
        if (!reset_b) begin
            rw_q     <= 1'b1;
            addr_q   <= 16'h0000;
            wdata_q  <= 8'h00;
            region_q <= RGN_UNMAPPED;
        end else if (accept) begin
            rw_q     <= req_rw;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            region_q <= decode(req_addr, RAM_WORDS, ROM_WORDS);
        end
    end

    // RAM write lands on the edge that leaves RESP; reset forces
    // IDLE first, so an aborted write never commits.
    assign ram_we = (state == RESP) && !rw_q &&
                    (region_q == RGN_RAM);

    mem_array #(
        .DEPTH (RAM_WORDS)
    ) RAM (
        .clk   (ph2),
        .we    (ram_we),
        .waddr (addr_q[RAM_AW-1:0]),
        .wdata (wdata_q),
        .raddr (addr_q[RAM_AW-1:0]),
        .rdata (ram_rd)
    );

    // ROM is written only by the load port; CPU writes are dropped.
    mem_array #(
        .DEPTH (ROM_WORDS)
    ) ROM (
        .clk   (ph2),
        .we    (ld_en),
        .waddr (ld_addr[ROM_AW-1:0]),
        .wdata (ld_data),
        .raddr (addr_q[ROM_AW-1:0]),
        .rdata (rom_rd)
    );

    // Response outputs are zero outside the single RESP cycle.
    always_comb begin
        rsp_valid = (state == RESP);
        rsp_rdata = 8'h00;
        rsp_err   = 1'b0;
        if (state == RESP) begin
            unique case (region_q)
                RGN_RAM: begin
                    if (rw_q)
                        rsp_rdata = ram_rd;
                end
                RGN_ROM: begin
                    if (rw_q)
                        rsp_rdata = rom_rd;
                    else
                        rsp_err = ERR_EN;
                end
                default: begin
                    if (rw_q)
                        rsp_rdata = UNM_RDATA;
                    rsp_err = ERR_EN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table plus corner sequences.
// Expectations track MEM_RESPONDER_ERR_EN when it is defined.
module tb_mem_responder;

`ifdef MEM_RESPONDER_ERR_EN
    localparam logic       E_ERR = 1'b1;
    localparam logic [7:0] E_UNM = 8'h00;
`else
    localparam logic       E_ERR = 1'b0;
    localparam logic [7:0] E_UNM = 8'hFF;
`endif

    logic        ph2 = 1'b0;
    logic        reset_b = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_rw = 1'b1;
    logic [15:0] req_addr = 16'h0;
    logic [7:0]  req_wdata = 8'h0;
    logic        req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        ld_en = 1'b0;
    logic [11:0] ld_addr = 12'h0;
    logic [7:0]  ld_data = 8'h0;

    logic        q0_valid = 1'b0;
    logic        q0_rw = 1'b1;
    logic [15:0] q0_addr = 16'h0;
    logic [7:0]  q0_wdata = 8'h0;
    logic        q0_ready;
    logic        r0_valid;
    logic [7:0]  r0_rdata;
    logic        r0_err;
    logic        ld0_en = 1'b0;
    logic [11:0] ld0_addr = 12'h0;
    logic [7:0]  ld0_data = 8'h0;

    int checks = 0;
    int errors = 0;

    always #5 ph2 = ~ph2;

    mem_responder #(
        .RAM_WORDS   (4096),
        .ROM_WORDS   (4096),
        .WAIT_CYCLES (1)
    ) dut (
        .ph2       (ph2),
        .reset_b   (reset_b),
        .req_valid (req_valid),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    mem_responder #(
        .RAM_WORDS   (4096),
        .ROM_WORDS   (4096),
        .WAIT_CYCLES (0)
    ) dut0 (
        .ph2       (ph2),
        .reset_b   (reset_b),
        .req_valid (q0_valid),
        .req_rw    (q0_rw),
        .req_addr  (q0_addr),
        .req_wdata (q0_wdata),
        .req_ready (q0_ready),
        .rsp_valid (r0_valid),
        .rsp_rdata (r0_rdata),
        .rsp_err   (r0_err),
        .ld_en     (ld0_en),
        .ld_addr   (ld0_addr),
        .ld_data   (ld0_data)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One access on dut, starting and ending at a falling edge.
    task automatic access(input logic rw, input logic [15:0] a,
                          input logic [7:0] wd,
                          output logic [7:0] rd, output logic er,
                          output int lat);
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_wdata = wd;
        @(negedge ph2);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            chk("quiet_outputs", {23'd0, rsp_err, rsp_rdata}, 32'd0);
            @(negedge ph2);
            lat++;
        end
        chk("rsp_seen", 32'(rsp_valid), 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge ph2);
    endtask

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic        err;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [7:0] rd;
        logic       er;
        int         lat;

        dut.RAM.mem[12'h123]  = 8'h5A;
        dut.RAM.mem[12'hFFF]  = 8'h99;
        dut.ROM.mem[12'h000]  = 8'h12;
        dut.ROM.mem[12'h010]  = 8'h3C;
        dut.ROM.mem[12'h020]  = 8'h40;
        dut.ROM.mem[12'hFFF]  = 8'hEE;
        dut0.RAM.mem[12'h004] = 8'h33;

        vecs[0]  = '{1'b0, 16'h0004, 8'h75, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 16'h0004, 8'h00, 8'h75, 1'b0};
        vecs[2]  = '{1'b1, 16'h0123, 8'h00, 8'h5A, 1'b0};
        vecs[3]  = '{1'b0, 16'h0123, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 16'h0123, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 16'hF010, 8'h00, 8'h3C, 1'b0};
        vecs[6]  = '{1'b0, 16'hF010, 8'hAA, 8'h00, E_ERR};
        vecs[7]  = '{1'b1, 16'hF010, 8'h00, 8'h3C, 1'b0};
        vecs[8]  = '{1'b1, 16'h8000, 8'h00, E_UNM, E_ERR};
        vecs[9]  = '{1'b0, 16'h8000, 8'h11, 8'h00, E_ERR};
        vecs[10] = '{1'b1, 16'h0FFF, 8'h00, 8'h99, 1'b0};
        vecs[11] = '{1'b1, 16'h1000, 8'h00, E_UNM, E_ERR};
        vecs[12] = '{1'b1, 16'hEFFF, 8'h00, E_UNM, E_ERR};
        vecs[13] = '{1'b1, 16'hF000, 8'h00, 8'h12, 1'b0};

        repeat (2) @(negedge ph2);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset_b = 1'b1;
        @(negedge ph2);
        chk("rst_ready", 32'(req_ready), 32'd1);

        ld_en   = 1'b1;
        ld_addr = 12'hFFD;
        ld_data = 8'hF0;
        @(negedge ph2);
        ld_en = 1'b0;
        access(1'b1, 16'hFFFD, 8'h00, rd, er, lat);
        chk("ld_latency", 32'(lat), 32'd2);
        chk("ld_rdata", 32'(rd), 32'hF0);
        chk("ld_err", 32'(er), 32'd0);

        for (int i = 0; i < 14; i++) begin
            access(vecs[i].rw, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].rdata));
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].err));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
        end

        // Reset during WAIT aborts a pending RAM write.
        access(1'b0, 16'h0010, 8'h22, rd, er, lat);
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 16'h0010;
        req_wdata = 8'h55;
        @(negedge ph2);
        req_valid = 1'b0;
        chk("abort_in_wait", 32'(req_ready), 32'd0);
        reset_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ph2);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        reset_b = 1'b1;
        @(negedge ph2);
        access(1'b1, 16'h0010, 8'h00, rd, er, lat);
        chk("abort_readback", 32'(rd), 32'h22);

        // Load on the edge that ends a ROM read response.
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_addr  = 16'hF020;
        @(negedge ph2);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge ph2);
            lat++;
        end
        chk("ldrace_rsp", 32'(rsp_valid), 32'd1);
        ld_en   = 1'b1;
        ld_addr = 12'h020;
        ld_data = 8'h41;
        #1;
        chk("ldrace_old", 32'(rsp_rdata), 32'h40);
        @(negedge ph2);
        ld_en = 1'b0;
        access(1'b1, 16'hF020, 8'h00, rd, er, lat);
        chk("ldrace_new", 32'(rd), 32'h41);

        // Zero-wait instance under continuous requests.
        chk("z_ready0", 32'(q0_ready), 32'd1);
        q0_valid = 1'b1;
        q0_rw    = 1'b1;
        q0_addr  = 16'h0004;
        for (int i = 1; i <= 8; i++) begin
            @(negedge ph2);
            chk($sformatf("z_valid%0d", i), 32'(r0_valid), 32'(i % 2));
            chk($sformatf("z_ready%0d", i), 32'(q0_ready),
                32'(1 - (i % 2)));
            chk($sformatf("z_rdata%0d", i), 32'(r0_rdata),
                (i % 2 == 1) ? 32'h33 : 32'h0);
        end
        q0_valid = 1'b0;
        @(negedge ph2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
